// File: rtl/estagio_operandos_if.sv
// Operand-stage bus: instruction offer, ULA operands/result, debug read port.
interface estagio_operandos_if;
    logic       InstrValida;
    logic       InstrPronta;
    logic [3:0] InstrULAOp;
    logic [2:0] InstrRs;
    logic [2:0] InstrRt;
    logic [2:0] InstrRd;
    logic       InstrUsaImediato;
    logic [7:0] InstrImediato;
    logic [7:0] Entrada1;
    logic [7:0] Entrada2;
    logic [3:0] ULAOp;
    logic [7:0] Resultado;
    logic       Zero;
    logic       FlagZero;
    logic       Concluido;
    logic [2:0] LeituraEnd;
    logic [7:0] LeituraDado;

    modport master (
        output InstrValida, InstrULAOp, InstrRs, InstrRt, InstrRd,
        output InstrUsaImediato, InstrImediato, Resultado, Zero, LeituraEnd,
        input  InstrPronta, Entrada1, Entrada2, ULAOp, FlagZero,
        input  Concluido, LeituraDado
    );

    modport slave (
        input  InstrValida, InstrULAOp, InstrRs, InstrRt, InstrRd,
        input  InstrUsaImediato, InstrImediato, Resultado, Zero, LeituraEnd,
        output InstrPronta, Entrada1, Entrada2, ULAOp, FlagZero,
        output Concluido, LeituraDado
    );
endinterface

// File: rtl/estagio_operandos.sv
// Operand fetch/execute/writeback stage: 8x8 register file feeding an external ULA,
// one instruction per four cycles.
module estagio_operandos (
    input logic                clock,
    input logic                reset,
    estagio_operandos_if.slave bus
);
    typedef enum logic [1:0] {
        OCIOSO,
        LEITURA,
        EXECUTA,
        ESCRITA
    } estado_t;

    estado_t    r_estado;
    estado_t    w_prox;

    logic [7:0] r_banco [8];
    logic [3:0] r_op;
    logic [2:0] r_rs;
    logic [2:0] r_rt;
    logic [2:0] r_rd;
    logic       r_usa_imm;
    logic [7:0] r_imm;
    logic [7:0] r_ent1;
    logic [7:0] r_ent2;
    logic [3:0] r_ulaop;
    logic [7:0] r_res;
    logic       r_zero;
    logic       r_flag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado  <= OCIOSO;
            for (int i = 0; i < 8; i++) r_banco[i] <= 8'h00;
            r_op      <= 4'h0;
            r_rs      <= 3'd0;
            r_rt      <= 3'd0;
            r_rd      <= 3'd0;
            r_usa_imm <= 1'b0;
            r_imm     <= 8'h00;
            r_ent1    <= 8'h00;
            r_ent2    <= 8'h00;
            r_ulaop   <= 4'h0;
            r_res     <= 8'h00;
            r_zero    <= 1'b0;
            r_flag    <= 1'b0;
        end else begin
            r_estado <= w_prox;
            unique case (r_estado)
                OCIOSO: begin
                    if (bus.InstrValida) begin
                        r_op      <= bus.InstrULAOp;
                        r_rs      <= bus.InstrRs;
                        r_rt      <= bus.InstrRt;
                        r_rd      <= bus.InstrRd;
                        r_usa_imm <= bus.InstrUsaImediato;
                        r_imm     <= bus.InstrImediato;
                    end
                end
                LEITURA: begin
                    r_ent1  <= r_banco[r_rs];
                    r_ent2  <= r_usa_imm ? r_imm : r_banco[r_rt];
                    r_ulaop <= r_op;
                end
                EXECUTA: begin
                    r_res  <= bus.Resultado;
                    r_zero <= bus.Zero;
                end
                ESCRITA: begin
                    // Register 0 is hardwired: it is never written, so it stays 0x00.
                    if (r_rd != 3'd0) r_banco[r_rd] <= r_res;
                    r_flag <= r_zero;
                end
            endcase
        end
    end

    always_comb begin
        w_prox = r_estado;
        unique case (r_estado)
            OCIOSO:  if (bus.InstrValida) w_prox = LEITURA;
            LEITURA: w_prox = EXECUTA;
            EXECUTA: w_prox = ESCRITA;
            ESCRITA: w_prox = OCIOSO;
        endcase
    end

    assign bus.InstrPronta = (r_estado == OCIOSO);
    assign bus.Concluido   = (r_estado == ESCRITA);
    assign bus.Entrada1    = r_ent1;
    assign bus.Entrada2    = r_ent2;
    assign bus.ULAOp       = r_ulaop;
    assign bus.FlagZero    = r_flag;
    assign bus.LeituraDado = r_banco[bus.LeituraEnd];
endmodule

// File: tb/tb_estagio_operandos.sv
// Self-checking bench for estagio_operandos: directed cases, back-to-back offers,
// reset abort and random instructions against an array-based model.
module tb_estagio_operandos;
    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   m_reg [8];
    int   m_flag;

    estagio_operandos_if bus ();

    estagio_operandos dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ULA stub: modular add and zero flag.
    assign bus.Resultado = bus.Entrada1 + bus.Entrada2;
    assign bus.Zero      = (bus.Resultado == 8'h00);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        m_flag = 0;
    endtask

    task automatic exec(input string tag, input logic [3:0] op,
                        input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic usa,
                        input logic [7:0] imm);
        int e1, e2, res;
        @(negedge clock);
        chk({tag, ".pronta_idle"}, bus.InstrPronta, 1);
        bus.InstrValida      = 1'b1;
        bus.InstrULAOp       = op;
        bus.InstrRs          = rs;
        bus.InstrRt          = rt;
        bus.InstrRd          = rd;
        bus.InstrUsaImediato = usa;
        bus.InstrImediato    = imm;
        e1  = m_reg[rs];
        e2  = usa ? int'(imm) : m_reg[rt];
        res = (e1 + e2) % 256;
        @(posedge clock);
        @(negedge clock);
        bus.InstrValida = 1'b0;
        chk({tag, ".pronta_leit"}, bus.InstrPronta, 0);
        chk({tag, ".concl_leit"}, bus.Concluido, 0);
        @(posedge clock);
        @(negedge clock);
        chk({tag, ".ent1"}, bus.Entrada1, e1);
        chk({tag, ".ent2"}, bus.Entrada2, e2);
        chk({tag, ".ulaop"}, bus.ULAOp, op);
        chk({tag, ".pronta_exec"}, bus.InstrPronta, 0);
        @(posedge clock);
        @(negedge clock);
        chk({tag, ".concl_esc"}, bus.Concluido, 1);
        bus.LeituraEnd = rd;
        #1;
        chk({tag, ".pre_write"}, bus.LeituraDado, m_reg[rd]);
        @(posedge clock);
        @(negedge clock);
        if (rd != 0) m_reg[rd] = res;
        m_flag = (res == 0) ? 1 : 0;
        chk({tag, ".concl_after"}, bus.Concluido, 0);
        chk({tag, ".pronta_after"}, bus.InstrPronta, 1);
        chk({tag, ".reg_rd"}, bus.LeituraDado, m_reg[rd]);
        chk({tag, ".flag"}, bus.FlagZero, m_flag);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.LeituraEnd = 3'(i);
            #1;
            chk($sformatf("%s.reg%0d", tag, i), bus.LeituraDado, m_reg[i]);
        end
    endtask

    initial begin
        int pulses;
        int first_p;
        int second_p;
        total = 0;
        bad   = 0;
        model_reset();
        bus.InstrValida      = 1'b0;
        bus.InstrULAOp       = 4'h0;
        bus.InstrRs          = 3'd0;
        bus.InstrRt          = 3'd0;
        bus.InstrRd          = 3'd0;
        bus.InstrUsaImediato = 1'b0;
        bus.InstrImediato    = 8'h00;
        bus.LeituraEnd       = 3'd0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst.ent1", bus.Entrada1, 0);
        chk("rst.ent2", bus.Entrada2, 0);
        chk("rst.ulaop", bus.ULAOp, 0);
        chk("rst.flag", bus.FlagZero, 0);
        chk("rst.concl", bus.Concluido, 0);
        reset = 1'b0;
        #1;
        chk("rst.pronta", bus.InstrPronta, 1);
        sweep("rst");

        exec("imm5", 4'h2, 3'd0, 3'd0, 3'd1, 1'b1, 8'h05);
        exec("r1r1", 4'h3, 3'd1, 3'd1, 3'd1, 1'b0, 8'h00);
        exec("rd0", 4'h1, 3'd0, 3'd0, 3'd0, 1'b1, 8'h00);
        exec("set80", 4'h0, 3'd0, 3'd0, 3'd2, 1'b1, 8'h80);
        exec("wrap", 4'h5, 3'd2, 3'd0, 3'd2, 1'b1, 8'h80);
        sweep("dir");

        // Held InstrValida: second offer taken only on return to idle.
        pulses   = 0;
        first_p  = -1;
        second_p = -1;
        @(negedge clock);
        bus.InstrValida      = 1'b1;
        bus.InstrULAOp       = 4'h7;
        bus.InstrRs          = 3'd0;
        bus.InstrRd          = 3'd4;
        bus.InstrUsaImediato = 1'b1;
        bus.InstrImediato    = 8'h11;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (c == 0) begin
                bus.InstrULAOp       = 4'h9;
                bus.InstrRs          = 3'd4;
                bus.InstrRt          = 3'd4;
                bus.InstrRd          = 3'd5;
                bus.InstrUsaImediato = 1'b0;
            end
            if (c == 4) bus.InstrValida = 1'b0;
            chk($sformatf("hold.pronta%0d", c), bus.InstrPronta,
                (c == 3 || c >= 7) ? 1 : 0);
            if (bus.Concluido === 1'b1) begin
                pulses++;
                if (first_p < 0) first_p = c;
                else second_p = c;
            end
        end
        m_reg[4] = 8'h11;
        m_reg[5] = 8'h22;
        m_flag   = 0;
        chk("hold.pulses", pulses, 2);
        chk("hold.gap", second_p - first_p, 4);
        chk("hold.flag", bus.FlagZero, m_flag);
        chk("hold.op", bus.ULAOp, 4'h9);
        sweep("hold");

        for (int n = 0; n < 16; n++)
            exec($sformatf("rnd%0d", n), 4'($urandom_range(15)),
                 3'($urandom_range(7)), 3'($urandom_range(7)),
                 3'($urandom_range(7)), 1'($urandom_range(1)),
                 8'($urandom_range(255)));
        sweep("rnd");

        // Reset during EXECUTA aborts the instruction.
        @(negedge clock);
        bus.InstrValida      = 1'b1;
        bus.InstrRs          = 3'd0;
        bus.InstrRd          = 3'd3;
        bus.InstrUsaImediato = 1'b1;
        bus.InstrImediato    = 8'hFF;
        @(posedge clock);
        @(negedge clock);
        bus.InstrValida = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        #1;
        chk("abort.pronta", bus.InstrPronta, 1);
        chk("abort.concl", bus.Concluido, 0);
        chk("abort.ent2", bus.Entrada2, 0);
        chk("abort.flag", bus.FlagZero, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort.pronta_rel", bus.InstrPronta, 1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("abort.noconcl%0d", c), bus.Concluido, 0);
        end
        sweep("abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
